// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register for the 5-stage ARM core.
// Captures the decoded control, operands, immediates and source tags from ID
// each cycle. freeze holds all contents. flush inserts a bubble. A saturating
// counter records how many bubbles have been captured since reset.
//
// Valid semantics: exe_valid is the registered copy of valid_in. It is 1 only
// when the EXE stage holds a real instruction. No ready signal exists: a
// downstream stall is signalled by freeze, which holds everything. Whenever
// exe_valid is 0, the control bits (wb_en, mem_r_en, mem_w_en, b, s) are also
// 0, so a bubble can never write or branch.
module id_exe_reg #(
    parameter int BIT_NUMBER   = 32,
    parameter int REG_NUM_BITS = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    c_in,
    input  logic                    valid_in,
    input  logic                    wb_en,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic                    b,
    input  logic                    s,
    input  logic                    imm,
    input  logic [REG_NUM_BITS-1:0] exe_cmd,
    input  logic [REG_NUM_BITS-1:0] dest,
    input  logic [REG_NUM_BITS-1:0] src1,
    input  logic [REG_NUM_BITS-1:0] src2,
    input  logic [11:0]             shift_operand,
    input  logic [23:0]             signed_imm_24,
    input  logic [BIT_NUMBER-1:0]   val_rn,
    input  logic [BIT_NUMBER-1:0]   val_rm,
    input  logic [BIT_NUMBER-1:0]   pc_in,
    output logic                    exe_wb_en,
    output logic                    exe_mem_r_en,
    output logic                    exe_mem_w_en,
    output logic                    exe_b,
    output logic                    exe_s,
    output logic                    exe_imm,
    output logic [REG_NUM_BITS-1:0] exe_exe_cmd,
    output logic [REG_NUM_BITS-1:0] exe_dest,
    output logic [REG_NUM_BITS-1:0] exe_src1,
    output logic [REG_NUM_BITS-1:0] exe_src2,
    output logic [11:0]             exe_shift_operand,
    output logic [23:0]             exe_signed_imm_24,
    output logic [BIT_NUMBER-1:0]   exe_val_rn,
    output logic [BIT_NUMBER-1:0]   exe_val_rm,
    output logic [BIT_NUMBER-1:0]   exe_pc,
    output logic                    exe_c,
    output logic                    exe_valid,
    output logic [CNT_WIDTH-1:0]    bubble_cnt
);

    // A bubble is captured on a flush, or on a load while ID has no real
    // instruction. A frozen cycle captures nothing.
    logic bubble;
    assign bubble = flush | (~freeze & ~valid_in);

    // Pipeline register: flush beats freeze, and freeze beats load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wb_en         <= 1'b0;
            exe_mem_r_en      <= 1'b0;
            exe_mem_w_en      <= 1'b0;
            exe_b             <= 1'b0;
            exe_s             <= 1'b0;
            exe_imm           <= 1'b0;
            exe_exe_cmd       <= '0;
            exe_dest          <= '0;
            exe_src1          <= '0;
            exe_src2          <= '0;
            exe_shift_operand <= '0;
            exe_signed_imm_24 <= '0;
            exe_val_rn        <= '0;
            exe_val_rm        <= '0;
            exe_pc            <= '0;
            exe_c             <= 1'b0;
            exe_valid         <= 1'b0;
        end else if (flush) begin
            exe_wb_en         <= 1'b0;
            exe_mem_r_en      <= 1'b0;
            exe_mem_w_en      <= 1'b0;
            exe_b             <= 1'b0;
            exe_s             <= 1'b0;
            exe_imm           <= 1'b0;
            exe_exe_cmd       <= '0;
            exe_dest          <= '0;
            exe_src1          <= '0;
            exe_src2          <= '0;
            exe_shift_operand <= '0;
            exe_signed_imm_24 <= '0;
            exe_val_rn        <= '0;
            exe_val_rm        <= '0;
            exe_pc            <= '0;
            exe_c             <= 1'b0;
            exe_valid         <= 1'b0;
        end else if (!freeze) begin
            // On a hazard bubble from ID the side-effecting controls are
            // gated off, but the data fields still load.
            exe_wb_en         <= wb_en    & valid_in;
            exe_mem_r_en      <= mem_r_en & valid_in;
            exe_mem_w_en      <= mem_w_en & valid_in;
            exe_b             <= b        & valid_in;
            exe_s             <= s        & valid_in;
            exe_imm           <= imm;
            exe_exe_cmd       <= exe_cmd;
            exe_dest          <= dest;
            exe_src1          <= src1;
            exe_src2          <= src2;
            exe_shift_operand <= shift_operand;
            exe_signed_imm_24 <= signed_imm_24;
            exe_val_rn        <= val_rn;
            exe_val_rm        <= val_rm;
            exe_pc            <= pc_in;
            exe_c             <= c_in;
            exe_valid         <= valid_in;
        end
    end

    // Debug bubble counter: it saturates at all-ones and never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CNT_WIDTH{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed testbench for id_exe_reg. It uses a 4-bit bubble counter so the
// saturation behaviour can be reached quickly.
module tb_id_exe_reg;

    localparam int BN = 32;
    localparam int RN = 4;
    localparam int CW = 4;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          freeze, flush, c_in, valid_in, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [RN-1:0] exe_cmd, dest, src1, src2;
    logic [11:0]   shift_operand;
    logic [23:0]   signed_imm_24;
    logic [BN-1:0] val_rn, val_rm, pc_in;

    logic          exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm, exe_c, exe_valid;
    logic [RN-1:0] exe_exe_cmd, exe_dest, exe_src1, exe_src2;
    logic [11:0]   exe_shift_operand;
    logic [23:0]   exe_signed_imm_24;
    logic [BN-1:0] exe_val_rn, exe_val_rm, exe_pc;
    logic [CW-1:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CW-1:0] exp_cnt;
    logic [CW-1:0] exp_sat;

    id_exe_reg #(.BIT_NUMBER(BN), .REG_NUM_BITS(RN), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .c_in(c_in),
        .valid_in(valid_in), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .b(b), .s(s), .imm(imm), .exe_cmd(exe_cmd), .dest(dest), .src1(src1),
        .src2(src2), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .val_rn(val_rn), .val_rm(val_rm), .pc_in(pc_in),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm), .exe_exe_cmd(exe_exe_cmd),
        .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
        .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_pc(exe_pc),
        .exe_c(exe_c), .exe_valid(exe_valid), .bubble_cnt(bubble_cnt)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all_ones();
        freeze = 0; flush = 0; c_in = 1; valid_in = 1; wb_en = 1; mem_r_en = 1;
        mem_w_en = 1; b = 1; s = 1; imm = 1; exe_cmd = 4'hF; dest = 4'hE;
        src1 = 4'hD; src2 = 4'hC; shift_operand = 12'hABC; signed_imm_24 = 24'h876543;
        val_rn = 32'hDEAD_BEEF; val_rm = 32'hCAFE_F00D; pc_in = 32'h0000_1004;
    endtask

    task automatic drive_clear();
        freeze = 0; flush = 0; c_in = 0; valid_in = 1; wb_en = 0; mem_r_en = 0;
        mem_w_en = 0; b = 0; s = 0; imm = 0; exe_cmd = '0; dest = '0; src1 = '0;
        src2 = '0; shift_operand = '0; signed_imm_24 = '0; val_rn = '0; val_rm = '0;
        pc_in = '0;
    endtask

    task automatic test_reset();
        drive_all_ones();
        rst = 1;
        tick();
        tick();
        // Let the outputs go nonzero, then reset in the middle of the cycle.
        #2 rst = 0;
        #1;
        n_checks++; if (exe_val_rn !== 32'h0) begin n_fail++; $display("FAIL reset_val_rn got=%h exp=0", exe_val_rn); end
        n_checks++; if (exe_wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got=%b exp=0", exe_wb_en); end
        n_checks++; if (exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", exe_valid); end
        n_checks++; if (exe_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", exe_pc); end
        n_checks++; if (exe_signed_imm_24 !== 24'h0) begin n_fail++; $display("FAIL reset_imm24 got=%h exp=0", exe_signed_imm_24); end
        n_checks++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", bubble_cnt); end
        // Outputs must stay zero across an edge while reset is still low.
        tick();
        n_checks++; if (exe_val_rm !== 32'h0) begin n_fail++; $display("FAIL reset_hold_val_rm got=%h exp=0", exe_val_rm); end
        rst = 1;
        drive_clear();
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_load();
        drive_clear();
        valid_in = 1; wb_en = 1; exe_cmd = 4'b0010; val_rn = 32'h1234_5678; dest = 4'd3;
        src1 = 4'd7; c_in = 1; pc_in = 32'h0000_0104; shift_operand = 12'h5A5;
        signed_imm_24 = 24'hFFFFFE; val_rm = 32'h8000_0001;
        tick();
        n_checks++; if (exe_wb_en !== 1'b1) begin n_fail++; $display("FAIL load_wb_en got=%b exp=1", exe_wb_en); end
        n_checks++; if (exe_exe_cmd !== 4'b0010) begin n_fail++; $display("FAIL load_cmd got=%b exp=0010", exe_exe_cmd); end
        n_checks++; if (exe_val_rn !== 32'h1234_5678) begin n_fail++; $display("FAIL load_val_rn got=%h exp=12345678", exe_val_rn); end
        n_checks++; if (exe_dest !== 4'd3) begin n_fail++; $display("FAIL load_dest got=%0d exp=3", exe_dest); end
        n_checks++; if (exe_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid got=%b exp=1", exe_valid); end
        n_checks++; if (exe_src1 !== 4'd7) begin n_fail++; $display("FAIL load_src1 got=%0d exp=7", exe_src1); end
        n_checks++; if (exe_c !== 1'b1) begin n_fail++; $display("FAIL load_c got=%b exp=1", exe_c); end
        n_checks++; if (exe_pc !== 32'h0000_0104) begin n_fail++; $display("FAIL load_pc got=%h exp=00000104", exe_pc); end
        n_checks++; if (exe_shift_operand !== 12'h5A5) begin n_fail++; $display("FAIL load_shift got=%h exp=5a5", exe_shift_operand); end
        n_checks++; if (exe_signed_imm_24 !== 24'hFFFFFE) begin n_fail++; $display("FAIL load_imm24 got=%h exp=fffffe", exe_signed_imm_24); end
        n_checks++; if (exe_val_rm !== 32'h8000_0001) begin n_fail++; $display("FAIL load_val_rm got=%h exp=80000001", exe_val_rm); end
        n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt got=%h exp=%h", bubble_cnt, exp_cnt); end
    endtask

    task automatic test_freeze();
        drive_clear();
        val_rn = 32'hAAAA_0001; dest = 4'd5; mem_r_en = 1;
        tick();
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            // Changing inputs, including a hazard bubble that must not count.
            val_rn = 32'h5555_0000 + i; dest = 4'd9; mem_r_en = 0; valid_in = 0;
            tick();
            n_checks++; if (exe_val_rn !== 32'hAAAA_0001) begin n_fail++; $display("FAIL freeze_val_rn[%0d] got=%h exp=aaaa0001", i, exe_val_rn); end
            n_checks++; if (exe_dest !== 4'd5) begin n_fail++; $display("FAIL freeze_dest[%0d] got=%0d exp=5", i, exe_dest); end
            n_checks++; if (exe_mem_r_en !== 1'b1) begin n_fail++; $display("FAIL freeze_mem_r[%0d] got=%b exp=1", i, exe_mem_r_en); end
            n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL freeze_cnt[%0d] got=%h exp=%h", i, bubble_cnt, exp_cnt); end
        end
        freeze = 0; valid_in = 1; val_rn = 32'hBBBB_0002; dest = 4'd6;
        tick();
        n_checks++; if (exe_val_rn !== 32'hBBBB_0002) begin n_fail++; $display("FAIL unfreeze_val_rn got=%h exp=bbbb0002", exe_val_rn); end
        n_checks++; if (exe_dest !== 4'd6) begin n_fail++; $display("FAIL unfreeze_dest got=%0d exp=6", exe_dest); end
    endtask

    task automatic test_flush_freeze();
        drive_all_ones();
        tick();
        flush = 1; freeze = 1;
        tick();
        exp_cnt = exp_cnt + 1;
        n_checks++; if (exe_val_rn !== 32'h0) begin n_fail++; $display("FAIL flush_val_rn got=%h exp=0", exe_val_rn); end
        n_checks++; if (exe_wb_en !== 1'b0) begin n_fail++; $display("FAIL flush_wb_en got=%b exp=0", exe_wb_en); end
        n_checks++; if (exe_b !== 1'b0) begin n_fail++; $display("FAIL flush_b got=%b exp=0", exe_b); end
        n_checks++; if (exe_imm !== 1'b0) begin n_fail++; $display("FAIL flush_imm got=%b exp=0", exe_imm); end
        n_checks++; if (exe_pc !== 32'h0) begin n_fail++; $display("FAIL flush_pc got=%h exp=0", exe_pc); end
        n_checks++; if (exe_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", exe_valid); end
        n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt got=%h exp=%h", bubble_cnt, exp_cnt); end
        flush = 0; freeze = 0;
    endtask

    task automatic test_hazard_bubble();
        drive_clear();
        valid_in = 0; mem_w_en = 1; b = 1; wb_en = 1; s = 1; mem_r_en = 1;
        val_rn = 32'h0BAD_CAFE; dest = 4'd12;
        tick();
        exp_cnt = exp_cnt + 1;
        n_checks++; if (exe_mem_w_en !== 1'b0) begin n_fail++; $display("FAIL hazard_mem_w got=%b exp=0", exe_mem_w_en); end
        n_checks++; if (exe_b !== 1'b0) begin n_fail++; $display("FAIL hazard_b got=%b exp=0", exe_b); end
        n_checks++; if (exe_wb_en !== 1'b0) begin n_fail++; $display("FAIL hazard_wb got=%b exp=0", exe_wb_en); end
        n_checks++; if (exe_s !== 1'b0) begin n_fail++; $display("FAIL hazard_s got=%b exp=0", exe_s); end
        n_checks++; if (exe_mem_r_en !== 1'b0) begin n_fail++; $display("FAIL hazard_mem_r got=%b exp=0", exe_mem_r_en); end
        n_checks++; if (exe_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_valid got=%b exp=0", exe_valid); end
        n_checks++; if (exe_val_rn !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL hazard_data got=%h exp=0badcafe", exe_val_rn); end
        n_checks++; if (exe_dest !== 4'd12) begin n_fail++; $display("FAIL hazard_dest got=%0d exp=12", exe_dest); end
        n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL hazard_cnt got=%h exp=%h", bubble_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_freeze();
        drive_all_ones();
        tick();
        freeze = 1;
        tick();
        #2 rst = 0;
        #1;
        n_checks++; if (exe_val_rn !== 32'h0) begin n_fail++; $display("FAIL rst_freeze_val_rn got=%h exp=0", exe_val_rn); end
        n_checks++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_freeze_cnt got=%h exp=0", bubble_cnt); end
        tick();
        rst = 1;
        freeze = 0; val_rn = 32'h7777_1111;
        tick();
        exp_cnt = 0;
        n_checks++; if (exe_val_rn !== 32'h7777_1111) begin n_fail++; $display("FAIL rst_release_load got=%h exp=77771111", exe_val_rn); end
        n_checks++; if (exe_valid !== 1'b1) begin n_fail++; $display("FAIL rst_release_valid got=%b exp=1", exe_valid); end
        n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL rst_release_cnt got=%h exp=%h", bubble_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        drive_clear();
        flush = 1;
        exp_sat = bubble_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_sat != 4'hF) exp_sat = exp_sat + 1;
            n_checks++; if (bubble_cnt !== exp_sat) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%h exp=%h", i, bubble_cnt, exp_sat); end
        end
        flush = 0;
        n_checks++; if (bubble_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final got=%h exp=f", bubble_cnt); end
    endtask

    initial begin
        drive_clear();
        rst = 0;
        tick();
        tick();
        test_reset();
        test_load();
        test_freeze();
        test_flush_freeze();
        test_hazard_bubble();
        test_reset_mid_freeze();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
